// File: rtl/utmi_tx_serializer.sv
// UTMI transmit serializer: prepends SYNC, shifts bytes out LSB first one bit per 4-clock slot, then EOP.
// Build option: define TX_HS_SYNC_EN for the 32-bit high-speed SYNC (31 zeros then a 1).
module utmi_tx_serializer #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int          EOP_BITS     = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       TxValid,
    input  logic [7:0] DataIn,
    input  logic       stuff,
    output logic       TxReady,
    output logic       data_out,
    output logic [1:0] bit_stuff_en,
    output logic [1:0] edge_count,
    output logic       data_done,
    output logic       tx_active
);

`ifdef TX_HS_SYNC_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 3;
`endif
    localparam logic [CNT_W-1:0] SYNC_LAST = '1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(7);
    localparam int               EOP_W     = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;
    localparam logic [EOP_W-1:0] EOP_LAST  = EOP_W'(EOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOP  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [7:0]         shift_reg, shift_next;
    logic [CNT_W-1:0]   bit_idx_reg, bit_idx_next;
    logic [EOP_W-1:0]   eop_cnt_reg, eop_cnt_next;
    logic [1:0]         edge_count_reg, edge_count_next;
    logic               advance;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            eop_cnt_reg    <= '0;
            edge_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_idx_reg    <= bit_idx_next;
            eop_cnt_reg    <= eop_cnt_next;
            edge_count_reg <= edge_count_next;
        end
    end

    assign edge_count = edge_count_reg;
    assign tx_active  = (state_reg != IDLE);
    // The stuffer samples data_out on the slot-event clock; a stuff bit freezes the stream for that slot.
    assign advance    = (edge_count_reg == 2'd3) && !stuff;

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_idx_next    = bit_idx_reg;
        eop_cnt_next    = eop_cnt_reg;
        edge_count_next = (state_reg == IDLE) ? 2'd0 : edge_count_reg + 2'd1;
        TxReady         = 1'b0;
        data_out        = 1'b1;
        bit_stuff_en    = 2'b00;
        data_done       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (TxValid) begin
                    state_next   = SYNC;
                    shift_next   = SYNC_PATTERN;
                    bit_idx_next = '0;
                end
            end
            SYNC, DATA: begin
                bit_stuff_en = (state_reg == SYNC) ? 2'b01 : 2'b10;
`ifdef TX_HS_SYNC_EN
                data_out = (state_reg == SYNC) ? (bit_idx_reg == SYNC_LAST) : shift_reg[0];
`else
                data_out = shift_reg[0];
`endif
                if (advance) begin
                    if (bit_idx_reg == ((state_reg == SYNC) ? SYNC_LAST : DATA_LAST)) begin
                        bit_idx_next = '0;
                        if (TxValid) begin
                            TxReady    = 1'b1;
                            shift_next = DataIn;
                            state_next = DATA;
                        end else begin
                            eop_cnt_next = '0;
                            state_next   = EOP;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + CNT_W'(1);
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end
            end
            EOP: begin
                bit_stuff_en = 2'b10;
                data_done    = 1'b1;
                data_out     = (eop_cnt_reg == EOP_LAST);
                if (advance) begin
                    if (eop_cnt_reg == EOP_LAST) begin
                        eop_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        eop_cnt_next = eop_cnt_reg + EOP_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_utmi_tx_serializer.sv
// Directed bench for utmi_tx_serializer: table of packets with hand-computed serial streams,
// plus reset-state and mid-packet reset sequences.
module tb_utmi_tx_serializer;

`ifdef TX_HS_SYNC_EN
    localparam int          SYNC_LEN  = 32;
    localparam logic [63:0] SYNC_BITS = 64'h0000_0000_8000_0000;
`else
    localparam int          SYNC_LEN  = 8;
    localparam logic [63:0] SYNC_BITS = 64'h0000_0000_0000_0080;
`endif
    localparam int NV = 8;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       TxValid = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic       stuff = 1'b0;
    logic       TxReady;
    logic       data_out;
    logic [1:0] bit_stuff_en;
    logic [1:0] edge_count;
    logic       data_done;
    logic       tx_active;

    int n_checks = 0;
    int n_fail   = 0;

    utmi_tx_serializer dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .TxValid      (TxValid),
        .DataIn       (DataIn),
        .stuff        (stuff),
        .TxReady      (TxReady),
        .data_out     (data_out),
        .bit_stuff_en (bit_stuff_en),
        .edge_count   (edge_count),
        .data_done    (data_done),
        .tx_active    (tx_active)
    );

    always #5 Clk = ~Clk;

    // pay: consumed bits after SYNC, bit i sent i-th; byte k of bytes_in at [8k+:8]
    typedef struct {
        int          n;
        logic [23:0] bytes_in;
        bit          has_stuff;
        int          stuff_off;
        bit          glitch;
        logic [31:0] pay;
        int          pay_len;
        int          slots;
        int          on_slots;
        int          readies;
        int          last_off;
        int          dd_clocks;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".TxReady"},      64'(TxReady),      64'd0);
        chk({tag, ".data_out"},     64'(data_out),     64'd1);
        chk({tag, ".bit_stuff_en"}, 64'(bit_stuff_en), 64'd0);
        chk({tag, ".edge_count"},   64'(edge_count),   64'd0);
        chk({tag, ".data_done"},    64'(data_done),    64'd0);
        chk({tag, ".tx_active"},    64'(tx_active),    64'd0);
    endtask

    task automatic run_vec(input int vi);
        vec_t        v;
        int          slot_cnt, nbits, ready_cnt, last_ready, dd, act, c01, c10, cyc, idx, stuff_abs;
        bit          started, done;
        logic [63:0] got, expv;
        string       tag;
        v = vecs[vi];
        slot_cnt = 0; nbits = 0; ready_cnt = 0; last_ready = -1000; dd = 0;
        act = 0; c01 = 0; c10 = 0; cyc = 0; idx = 0; started = 0; done = 0; got = '0;
        stuff_abs = SYNC_LEN + v.stuff_off;
        tag = $sformatf("vec%0d", vi);

        @(posedge Clk); #1;
        TxValid = 1'b1;
        DataIn  = v.bytes_in[7:0];
        stuff   = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge Clk);
            cyc++;
            if (TxReady) begin
                ready_cnt++;
                last_ready = slot_cnt;
                idx++;
            end
            if (tx_active) begin
                started = 1;
                act++;
                if (data_done) dd++;
                if (bit_stuff_en == 2'b01) c01++;
                if (bit_stuff_en == 2'b10) c10++;
                if (edge_count == 2'd3) begin
                    if (!stuff) begin
                        if (nbits < 64) got[nbits] = data_out;
                        nbits++;
                    end
                    slot_cnt++;
                end
            end else if (started) begin
                done = 1;
            end
            if (!done) begin
                @(posedge Clk); #1;
                TxValid = (idx < v.n) || (!started && !tx_active);
                DataIn  = (idx < 3) ? v.bytes_in[8*idx +: 8] : 8'h00;
                stuff   = v.has_stuff && tx_active && (slot_cnt == stuff_abs);
                if (v.glitch && tx_active && edge_count != 2'd3) begin
                    TxValid = 1'($urandom_range(0, 1));
                    DataIn  = 8'($urandom_range(0, 255));
                end
            end
        end
        TxValid = 1'b0;
        stuff   = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.timeout: packet still active after %0d clocks, required end of packet", tag, cyc);
        end
        expv = (64'(v.pay) << SYNC_LEN) | SYNC_BITS;
        chk({tag, ".nbits"},       64'(nbits),      64'(SYNC_LEN + v.pay_len));
        chk({tag, ".stream"},      got,             expv);
        chk({tag, ".slots"},       64'(slot_cnt),   64'(SYNC_LEN + v.slots));
        chk({tag, ".active_clk"},  64'(act),        64'(4 * (SYNC_LEN + v.slots)));
        chk({tag, ".stuff_on_clk"},  64'(c10),      64'(4 * v.on_slots));
        chk({tag, ".stuff_off_clk"}, 64'(c01),      64'(4 * (SYNC_LEN + v.slots - v.on_slots)));
        chk({tag, ".readies"},     64'(ready_cnt),  64'(v.readies));
        if (v.readies > 0)
            chk({tag, ".last_ready"}, 64'(last_ready), 64'(SYNC_LEN + v.last_off));
        chk({tag, ".done_clk"},    64'(dd),         64'(v.dd_clocks));
        chk({tag, ".idle_out"},    64'({data_out, bit_stuff_en}), 64'b100);
        $display("vec %0d: bits=%0d slots=%0d readies=%0d last_ready=%0d done_clk=%0d stream=0x%0h",
                 vi, nbits, slot_cnt, ready_cnt, last_ready, dd, got);
    endtask

    initial begin
        //         n  bytes         stf off glt pay             len slt on rdy last dd
        vecs[0] = '{1, 24'h0000A5, 0,  0, 0, 32'h0000_04A5, 11, 11, 11, 1, -1, 12};
        vecs[1] = '{2, 24'h0001FF, 0,  0, 0, 32'h0004_01FF, 19, 19, 19, 2,  7, 12};
        vecs[2] = '{2, 24'h0001FF, 1,  5, 0, 32'h0004_01FF, 19, 20, 20, 2,  8, 12};
        vecs[3] = '{1, 24'h0000A5, 1,  8, 0, 32'h0000_04A5, 11, 12, 12, 1, -1, 16};
        vecs[4] = '{0, 24'h000000, 0,  0, 0, 32'h0000_0004,  3,  3,  3, 0,  0, 12};
        vecs[5] = '{3, 24'h81003C, 0,  0, 0, 32'h0481_003C, 27, 27, 27, 3, 15, 12};
        vecs[6] = '{1, 24'h0000A5, 1, -5, 0, 32'h0000_04A5, 11, 12, 11, 1,  0, 12};
        vecs[7] = '{2, 24'h003CA5, 0,  0, 1, 32'h0004_3CA5, 19, 19, 19, 2,  7, 12};

        repeat (3) @(negedge Clk);
        check_reset_vals("reset");
        $display("reset: data_out=%0b tx_active=%0b edge_count=%0d", data_out, tx_active, edge_count);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset asserted mid-DATA, then a fresh packet must start again with SYNC
        @(posedge Clk); #1;
        TxValid = 1'b1;
        DataIn  = 8'hA5;
        repeat (4 * (SYNC_LEN + 3) + 2) @(negedge Clk);
        chk("midrst.in_data", 64'(bit_stuff_en), 64'b10);
        #2;
        Rst     = 1'b0;
        TxValid = 1'b0;
        @(negedge Clk);
        check_reset_vals("midrst");
        $display("midrst: data_out=%0b tx_active=%0b data_done=%0b", data_out, tx_active, data_done);
        Rst = 1'b1;
        @(negedge Clk);
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/utmi_tx_serializer.md
Name: utmi_tx_serializer

Overview:
- Transmit-side parallel-to-serial stage that feeds the UTMI bit stuffer.
- Accepts bytes from the UTMI link side (TxValid/DataIn/TxReady) and prepends SYNC. Shifts bits out LSB first, one per bit slot, and generates the bit-slot phase (edge_count), the stuffer mode (bit_stuff_en) and the end-of-packet flag (data_done).
- Stalls its shift register whenever the stuffer inserts a stuff bit.

Parameters:
- SYNC_PATTERN, 8'h80, SYNC byte sent LSB first (seven 0s then a 1).
- EOP_BITS, 3, bit slots data_done is held after the last data bit (SE0, SE0, J).

Ports:
- Clk  input  1  clock, 4x bit rate.
- Rst  input  1  reset, asynchronous, active-low.
- TxValid  input  1  link has a byte to send; deassertion at a byte boundary ends the packet.
- DataIn  input  8  byte to transmit.
- stuff  input  1  stuffer is inserting a stuff bit in the current slot.
- TxReady  output  1  one-clock pulse: DataIn accepted this clock.
- data_out  output  1  current serial bit, to stuffer data_in.
- bit_stuff_en  output  2  00 NO_OP, 01 STUFF_OFF, 10 STUFF_ON.
- edge_count  output  2  bit-slot phase; a slot completes when edge_count==3.
- data_done  output  1  EOP phase flag to the stuffer.
- tx_active  output  1  high from leaving IDLE until returning to IDLE.

Behaviour:
- Reset values: TxReady=0, data_out=1, bit_stuff_en=00, edge_count=0, data_done=0, tx_active=0, state=IDLE, shift register=0, bit index=0.
- Slot event: edge_count==3. Outside IDLE, edge_count increments modulo 4 every clock. In IDLE it is held at 0.
- Bit consumption: the stuffer registers data_out on the slot-event clock.
  - On each slot event with stuff=0, the serializer advances to its next bit on that same edge.
  - With stuff=1 it holds data_out, the shift register and the bit index unchanged.
- IDLE: bit_stuff_en=00, data_out=1. When TxValid=1, go to SYNC, load SYNC_PATTERN, bit index=0, tx_active=1.
- SYNC: bit_stuff_en=01, data_out=shift[0].
  - On the slot event that consumes bit 7, the next state depends on TxValid:
    - TxValid=1: load DataIn, pulse TxReady on that clock, go to DATA.
    - TxValid=0: go to EOP.
- DATA: bit_stuff_en=10, data_out=shift[0].
  - On the slot event that consumes bit 7 (stuff=0), the next state depends on TxValid:
    - TxValid=1: load DataIn, pulse TxReady, stay in DATA.
    - TxValid=0: go to EOP.
- EOP: data_done=1, bit_stuff_en=10, EOP counter starts at 0.
  - data_out=0 for counts 0..EOP_BITS-2; data_out=1 on the final count.
  - Counter advances on slot events with stuff=0. A pending stuff bit therefore delays EOP by exactly one slot.
  - After the slot event at count EOP_BITS-1: go to IDLE, data_done=0, tx_active=0, bit_stuff_en=00.
- TxReady: never asserted outside the load clocks; at most one pulse per 8 consumed bits.
- Changes to TxValid or DataIn mid-byte are ignored; both are sampled only at byte boundaries.
- Reset mid-packet: everything returns to reset values immediately; no EOP is emitted.

Optional Feature:
- Macro TX_HS_SYNC_EN.
- Defined: SYNC is 32 bits (31 zeros then a 1), counted with a 5-bit SYNC counter. The SYNC_PATTERN parameter is ignored.
- Undefined: 8-bit SYNC_PATTERN as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single byte 8'hA5, TxValid dropped after the TxReady pulse:
  - data_out across slots = 0,0,0,0,0,0,0,1 then 1,0,1,0,0,1,0,1 then EOP 0,0,1.
  - TxReady pulses exactly once; tx_active falls 4 clocks after the final EOP slot.
- Bytes 8'hFF, 8'h01 back-to-back with stuff=1 forced on the slot after six 1s:
  - data_out and bit index hold for one slot; the total packet is one slot longer than the no-stuff case.
  - The second TxReady is delayed by 4 clocks.
- stuff=1 on the first EOP slot: EOP lasts 4 slots and data_done stays high for 16+ clocks.
- TxValid toggled mid-byte, and DataIn changed mid-byte: no effect on the serial stream; only boundary sampling matters.
- Rst low in the middle of DATA: next clock all outputs equal reset values; a new TxValid restarts with SYNC.
- With TX_HS_SYNC_EN defined: 31 zero bits then a 1 precede the first data bit; the first TxReady occurs at slot 32.
